// File: rtl/conv_layer_param.sv
// rtl/conv_layer_param.sv - streaming KxK, CH-channel 2-D convolution layer; CONV_RELU_EN clamps negative results to 0
module conv_layer_param #(
  parameter int WIDTH     = 28,
  parameter int HEIGHT    = 28,
  parameter int K         = 5,
  parameter int CH        = 3,
  parameter int DATA_BITS = 8,
  parameter int W_BITS    = 8,
  parameter int OUT_BITS  = 12,
  parameter int SHIFT     = 0,
  localparam int AW       = $clog2(CH * (K * K + 1))
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic [DATA_BITS-1:0]   data_in,
  input  logic                   wt_we,
  input  logic [AW-1:0]          wt_addr,
  input  logic [W_BITS-1:0]      wt_data,
  output logic [CH*OUT_BITS-1:0] conv_out,
  output logic                   valid_out,
  output logic                   frame_done
);
  localparam int KK   = K * K;
  localparam int NW   = KK + 1;          // K*K weights followed by one bias per channel
  localparam int NP   = (KK + 1) / 2;    // partial sums left after the first adder level
  localparam int PROD = DATA_BITS + 1 + W_BITS;
  localparam int ACC  = DATA_BITS + W_BITS + 1 + $clog2(KK);
  localparam int CW   = $clog2(WIDTH);
  localparam int RW   = $clog2(HEIGHT);
  localparam logic signed [ACC-1:0] OMAX = (ACC'(1) <<< (OUT_BITS - 1)) - ACC'(1);
  localparam logic signed [ACC-1:0] OMIN = -(ACC'(1) <<< (OUT_BITS - 1));
  localparam logic [OUT_BITS-1:0] SMAX = {1'b0, {(OUT_BITS - 1){1'b1}}};
  localparam logic [OUT_BITS-1:0] SMIN = {1'b1, {(OUT_BITS - 1){1'b0}}};

  logic [CW-1:0]            col_q;
  logic [RW-1:0]            row_q;
  logic [DATA_BITS-1:0]     lb_q  [K-1][WIDTH];
  logic [DATA_BITS-1:0]     win_q [K][K];
  logic [DATA_BITS-1:0]     win_d [K][K];
  logic signed [W_BITS-1:0] wt_q  [CH*NW];
  logic signed [ACC-1:0]    part_d [CH][NP];
  logic signed [ACC-1:0]    part_q [CH][NP];
  logic                     s1_valid_q;
  logic                     s1_last_q;
  logic [CH*OUT_BITS-1:0]   res_d;
  logic [CH*OUT_BITS-1:0]   conv_out_q;
  logic                     valid_out_q;
  logic                     frame_done_q;
  logic                     win_ok;
  logic                     pix_last;

  // The accepted pixel completes a full window once K-1 rows and columns precede it.
  assign win_ok   = valid_in && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
  assign pix_last = (row_q == RW'(HEIGHT - 1)) && (col_q == CW'(WIDTH - 1));

  // Weight/bias register file; a write is seen by the datapath from the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH * NW; i++) wt_q[i] <= '0;
    end else if (wt_we && (int'(wt_addr) < CH * NW)) begin
      wt_q[wt_addr] <= wt_data;
    end
  end

  // Next window: shift one column left, new column from the line buffer plus the incoming pixel.
  always_comb begin
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) win_d[r][c] = win_q[r][c];
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
    for (int r = 0; r < K - 1; r++) win_d[r][K-1] = lb_q[K-2-r][col_q];
    win_d[K-1][K-1] = data_in;
  end

  // Raster position, line buffer and window advance only on accepted pixels; gaps freeze them.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      for (int i = 0; i < K - 1; i++)
        for (int j = 0; j < WIDTH; j++) lb_q[i][j] <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
    end else if (valid_in) begin
      if (col_q == CW'(WIDTH - 1)) begin
        col_q <= '0;
        row_q <= (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
      lb_q[0][col_q] <= data_in;
      for (int i = 1; i < K - 1; i++) lb_q[i][col_q] <= lb_q[i-1][col_q];
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_q[r][c] <= win_d[r][c];
    end
  end

  // Stage 1 datapath: signed products of the next window, summed in pairs.
  always_comb begin
    logic signed [PROD-1:0] prod;
    prod = '0;
    for (int ch = 0; ch < CH; ch++)
      for (int p = 0; p < NP; p++) part_d[ch][p] = '0;
    for (int ch = 0; ch < CH; ch++) begin
      for (int i = 0; i < KK; i++) begin
        prod = PROD'($signed({1'b0, win_d[i / K][i % K]})) * PROD'(wt_q[ch * NW + i]);
        part_d[ch][i / 2] = part_d[ch][i / 2] + ACC'(prod);
      end
    end
  end

  // Stage 1 register: pair sums of a completed window plus its frame-end tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      for (int ch = 0; ch < CH; ch++)
        for (int p = 0; p < NP; p++) part_q[ch][p] <= '0;
    end else begin
      s1_valid_q <= win_ok;
      s1_last_q  <= win_ok && pix_last;
      if (win_ok) begin
        for (int ch = 0; ch < CH; ch++)
          for (int p = 0; p < NP; p++) part_q[ch][p] <= part_d[ch][p];
      end
    end
  end

  // Stage 2 datapath: final sum, bias, arithmetic shift, saturation (and optional ReLU).
  always_comb begin
    logic signed [ACC-1:0]   acc;
    logic signed [ACC-1:0]   res;
    logic [OUT_BITS-1:0]     sat;
    res_d = '0;
    acc   = '0;
    res   = '0;
    sat   = '0;
    for (int ch = 0; ch < CH; ch++) begin
      acc = ACC'(wt_q[ch * NW + KK]);
      for (int p = 0; p < NP; p++) acc = acc + part_q[ch][p];
      res = acc >>> SHIFT;
      if (res > OMAX)      sat = SMAX;
      else if (res < OMIN) sat = SMIN;
      else                 sat = res[OUT_BITS-1:0];
`ifdef CONV_RELU_EN
      if (sat[OUT_BITS-1]) sat = '0;
`endif
      res_d[ch*OUT_BITS +: OUT_BITS] = sat;
    end
  end

  // Stage 2 register: outputs hold their last result between valid windows.
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_out_q   <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      valid_out_q  <= s1_valid_q;
      frame_done_q <= s1_last_q;
      if (s1_valid_q) conv_out_q <= res_d;
    end
  end

  assign conv_out   = conv_out_q;
  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_layer_param.sv
// tb/tb_conv_layer_param.sv - scoreboard bench for conv_layer_param against a direct convolution model
`timescale 1ns/1ps
module tb_conv_layer_param;
  localparam int WIDTH     = 28;
  localparam int HEIGHT    = 28;
  localparam int K         = 5;
  localparam int CH        = 3;
  localparam int DATA_BITS = 8;
  localparam int W_BITS    = 8;
  localparam int OUT_BITS  = 12;
  localparam int SHIFT     = 1;
  localparam int KK        = K * K;
  localparam int AW        = $clog2(CH * (KK + 1));
  localparam int NPIX      = WIDTH * HEIGHT;
  localparam int NOUT      = (WIDTH - K + 1) * (HEIGHT - K + 1);
  localparam int OMAX      = 2 ** (OUT_BITS - 1) - 1;
  localparam int OMIN      = -(2 ** (OUT_BITS - 1));

  localparam int W_CENTER = 0, W_RAND = 1;
  localparam int P_RC = 0, P_255 = 1, P_RAND = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   valid_in;
  logic [DATA_BITS-1:0]   data_in;
  logic                   wt_we;
  logic [AW-1:0]          wt_addr;
  logic [W_BITS-1:0]      wt_data;
  logic [CH*OUT_BITS-1:0] conv_out;
  logic                   valid_out;
  logic                   frame_done;

  conv_layer_param #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .K(K), .CH(CH), .DATA_BITS(DATA_BITS),
    .W_BITS(W_BITS), .OUT_BITS(OUT_BITS), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .conv_out(conv_out), .valid_out(valid_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [CH*OUT_BITS-1:0] data;
    bit                     last;
    longint                 at;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     passes = 0;
  int     out_cnt = 0;
  int     fd_cnt = 0;
  longint fd_at[$];

  int img   [HEIGHT][WIDTH];
  int wt_m  [CH][KK];
  int bias_m[CH];
  int pr = 0;
  int pc = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: direct convolution of the stored image over the window ending at (r,c).
  function automatic logic [CH*OUT_BITS-1:0] model_out(int r, int c);
    logic [CH*OUT_BITS-1:0] v;
    int acc;
    v = '0;
    for (int ch = 0; ch < CH; ch++) begin
      acc = bias_m[ch];
      for (int dr = 0; dr < K; dr++)
        for (int dc = 0; dc < K; dc++)
          acc += img[r-K+1+dr][c-K+1+dc] * wt_m[ch][dr*K+dc];
      acc = acc >>> SHIFT;
      if (acc > OMAX) acc = OMAX;
      else if (acc < OMIN) acc = OMIN;
`ifdef CONV_RELU_EN
      if (acc < 0) acc = 0;
`endif
      v[ch*OUT_BITS +: OUT_BITS] = acc[OUT_BITS-1:0];
    end
    return v;
  endfunction

  // Monitor: every presented output is matched against the oldest expectation.
  always @(negedge clk) begin
    if (valid_out) begin
      out_cnt++;
      if (frame_done) begin
        fd_cnt++;
        fd_at.push_back(cyc);
      end
      chk("output_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("conv_out", 64'(conv_out), 64'(mon_e.data));
        chk("frame_done", 64'(frame_done), 64'(mon_e.last));
        chk("latency_cycle", 64'(cyc), 64'(mon_e.at));
      end
    end else begin
      chk("frame_done_idle", 64'(frame_done), 64'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string name);
    chk({name, "_conv_out"}, 64'(conv_out), 64'(0));
    chk({name, "_valid_out"}, 64'(valid_out), 64'(0));
    chk({name, "_frame_done"}, 64'(frame_done), 64'(0));
  endtask

  task automatic model_clear();
    exp_q.delete();
    pr = 0;
    pc = 0;
    for (int ch = 0; ch < CH; ch++) begin
      bias_m[ch] = 0;
      for (int i = 0; i < KK; i++) wt_m[ch][i] = 0;
    end
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    valid_in = 1'b0;
    tick();
    model_clear();
    for (int i = 0; i < n; i++) begin
      chk_zero("in_reset");
      tick();
    end
    rst = 1'b0;
    tick();
    chk_zero("after_reset");
  endtask

  task automatic load_weights(int mode);
    int w;
    for (int ch = 0; ch < CH; ch++) begin
      for (int i = 0; i <= KK; i++) begin
        if (mode == W_CENTER) begin
          if (i == KK) w = 0;
          else if (ch == 0) w = (i == KK / 2) ? 1 : 0;
          else if (ch == 1) w = 1;
          else w = -1;
        end else begin
          w = (i == KK) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 6)) - 3;
        end
        if (i == KK) bias_m[ch] = w;
        else wt_m[ch][i] = w;
        wt_we   = 1'b1;
        wt_addr = AW'(ch * (KK + 1) + i);
        wt_data = W_BITS'(w);
        tick();
      end
    end
    wt_we = 1'b0;
  endtask

  task automatic send_pixel(int v);
    exp_t x;
    valid_in = 1'b1;
    data_in  = DATA_BITS'(v);
    img[pr][pc] = v;
    if (pr >= K - 1 && pc >= K - 1) begin
      x.data = model_out(pr, pc);
      x.last = (pr == HEIGHT - 1) && (pc == WIDTH - 1);
      x.at   = cyc + 2;
      exp_q.push_back(x);
    end
    pc++;
    if (pc == WIDTH) begin
      pc = 0;
      pr = (pr + 1) % HEIGHT;
    end
    tick();
    valid_in = 1'b0;
  endtask

  task automatic send_frame(int pat, int max_gap, int npix);
    int v;
    for (int i = 0; i < npix; i++) begin
      case (pat)
        P_RC:    v = pr + pc;
        P_255:   v = 255;
        default: v = int'($urandom_range(0, 255));
      endcase
      send_pixel(v);
      repeat ($urandom_range(0, max_gap)) tick();
    end
  endtask

  task automatic start_seg();
    out_cnt = 0;
    fd_cnt  = 0;
    fd_at.delete();
  endtask

  task automatic end_seg(string name, int exp_outs, int exp_fd);
    repeat (4) tick();
    chk({name, "_out_count"}, 64'(out_cnt), 64'(exp_outs));
    chk({name, "_frame_done_count"}, 64'(fd_cnt), 64'(exp_fd));
    chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    wt_we    = 1'b0;
    wt_addr  = '0;
    wt_data  = '0;
    model_clear();
    repeat (3) tick();
    chk_zero("reset_state");
    rst = 1'b0;
    tick();

    load_weights(W_CENTER);
    start_seg(); send_frame(P_RC, 0, NPIX);  end_seg("ramp", NOUT, 1);
    start_seg(); send_frame(P_255, 0, NPIX); end_seg("saturate", NOUT, 1);
    start_seg(); send_frame(P_RC, 3, NPIX);  end_seg("ramp_gaps", NOUT, 1);

    load_weights(W_RAND);
    start_seg(); send_frame(P_RAND, 2, NPIX); end_seg("random_gaps", NOUT, 1);

    load_weights(W_CENTER);
    send_frame(P_RC, 0, 400);
    do_reset(3);
    start_seg();
    load_weights(W_CENTER);
    send_frame(P_RC, 0, NPIX);
    end_seg("post_reset", NOUT, 1);

    load_weights(W_RAND);
    start_seg();
    repeat (3) send_frame(P_RAND, 0, NPIX);
    end_seg("back_to_back", 3 * NOUT, 3);
    chk("fd_pulses_recorded", 64'(fd_at.size()), 64'(3));
    if (fd_at.size() >= 3) begin
      chk("fd_spacing_1", 64'(fd_at[1] - fd_at[0]), 64'(NPIX));
      chk("fd_spacing_2", 64'(fd_at[2] - fd_at[1]), 64'(NPIX));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
